// File: rtl/vram_write_queue.sv
// vram_write_queue: buffers CPU framebuffer stores in a small FIFO and runs whole-screen fills.
// Ports: clk, rst (async active-low); req_valid/req_addr/req_data/req_is_word -> req_ready (store intake);
// fill_start/fill_value (fill command); vram_grant -> vram_we/vram_addr/vram_wdata (VRAM write port);
// busy, fill_done, drop_count (status).
module vram_write_queue #(
  parameter int DEPTH      = 4,
  parameter int VRAM_WORDS = 'h9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        req_is_word,
  output logic        req_ready,
  input  logic        fill_start,
  input  logic [31:0] fill_value,
  input  logic        vram_grant,
  output logic        vram_we,
  output logic [15:0] vram_addr,
  output logic [31:0] vram_wdata,
  output logic        busy,
  output logic        fill_done,
  output logic [7:0]  drop_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, FLUSH, FILL} state_t;
  state_t state;
  logic [47:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_next;
  logic [15:0] fill_cnt, hold_addr;
  logic [31:0] fill_val, hold_data;
  logic empty, full, accept, bad, push, pop, drop;
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:25], req_addr[23:18]};
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign req_ready = state == IDLE && !full;
  assign accept = req_valid && req_ready;
  assign bad = !req_is_word || req_addr[1:0] != 2'b00 || {16'b0, req_addr[17:2]} >= 32'(VRAM_WORDS);
  assign push = accept && req_addr[24] && !bad;
  assign drop = accept && req_addr[24] && bad;
  assign pop = state != FILL && !empty && vram_grant;
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  assign busy = state != IDLE || !empty;
  assign vram_we = state == FILL || !empty;
  // With nothing to present, the port repeats the last value it showed.
  assign vram_addr = state == FILL ? fill_cnt : (!empty ? mem[rd_ptr][47:32] : hold_addr);
  assign vram_wdata = state == FILL ? fill_val : (!empty ? mem[rd_ptr][31:0] : hold_data);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {req_addr[17:2], req_data};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fill_cnt   <= '0;
      fill_val   <= '0;
      fill_done  <= 1'b0;
      drop_count <= '0;
      hold_addr  <= '0;
      hold_data  <= '0;
    end else begin
      hold_addr <= vram_addr;
      hold_data <= vram_wdata;
      fill_done <= 1'b0;
      count     <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      case (state)
        IDLE:
          if (fill_start) begin
            fill_val <= fill_value;
            fill_cnt <= '0;
            // Decide on post-cycle occupancy so a same-cycle push still drains first
            // and a same-cycle final pop never leaves FLUSH waiting on an empty FIFO.
            state <= count_next == '0 ? FILL : FLUSH;
          end
        FLUSH:
          if (pop && count == (AW+1)'(1)) state <= FILL;
        FILL:
          if (vram_grant) begin
            fill_cnt <= fill_cnt + 16'd1;
            if (fill_cnt == 16'(VRAM_WORDS - 1)) begin
              state     <= IDLE;
              fill_done <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_write_queue.sv
// tb_vram_write_queue: directed checks of store queueing, drops, flush/fill and reset.
module tb_vram_write_queue;
  logic clk = 1'b0;
  logic rst, req_valid, req_is_word, req_ready, fill_start, vram_grant, vram_we, busy, fill_done;
  logic [31:0] req_addr, req_data, fill_value, vram_wdata;
  logic [15:0] vram_addr;
  logic [7:0] drop_count;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [47:0] wq[$];
  vram_write_queue dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_is_word(req_is_word), .req_ready(req_ready), .fill_start(fill_start), .fill_value(fill_value),
    .vram_grant(vram_grant), .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .busy(busy), .fill_done(fill_done), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst && vram_we && vram_grant) wq.push_back({vram_addr, vram_wdata});
    if (fill_done) done_cnt++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic w);
    req_valid = 1'b1; req_addr = a; req_data = d; req_is_word = w;
    cyc();
    req_valid = 1'b0;
  endtask
  initial begin
    int n, bad;
    logic [47:0] e;
    logic [3:0] rdy;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_is_word = 1'b0;
    fill_start = 1'b0; fill_value = '0; vram_grant = 1'b0;
    #1;
    chk("reset vram_we", vram_we, 0);
    chk("reset busy", busy, 0);
    chk("reset addr/data", {vram_addr, vram_wdata}, 0);
    chk("reset drop/done", {drop_count, fill_done}, 0);
    cyc(); cyc();
    rst = 1'b1;
    #1 chk("ready after reset", req_ready, 1);
    // single store
    vram_grant = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0100_0010; req_data = 32'hDEAD_BEEF; req_is_word = 1'b1;
    #1 chk("no same-cycle we", vram_we, 0);
    cyc();
    req_valid = 1'b0;
    #1 chk("single store port", {vram_we, vram_addr, vram_wdata}, {1'b1, 16'd4, 32'hDEAD_BEEF});
    cyc(); cyc();
    chk("single store idle", {vram_we, busy}, 0);
    chk("single store count", wq.size(), 1);
    chk("single store entry", wq[0], {16'd4, 32'hDEAD_BEEF});
    wq.delete();
    // fill FIFO with grant low, fifth store refused
    vram_grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = 32'h0100_0000 + 32'(4 * i); req_data = 32'h1000 + 32'(i); req_is_word = 1'b1;
      #1 if (i < 4) rdy[i] = req_ready;
      if (i == 4) chk("fifth store refused", req_ready, 0);
      cyc();
    end
    req_valid = 1'b0;
    chk("first four ready", rdy, 4'hF);
    #1 chk("full head presented", {vram_we, busy, vram_addr, vram_wdata}, {2'b11, 16'd0, 32'h1000});
    vram_grant = 1'b1;
    repeat (5) cyc();
    chk("drain count", wq.size(), 4);
    bad = 0;
    foreach (wq[i]) if (wq[i] !== {16'(i), 32'h1000 + 32'(i)}) bad++;
    chk("drain order", bad, 0);
    chk("drained ready", {req_ready, vram_we, busy}, 3'b100);
    chk("hold addr/data after drain", {vram_addr, vram_wdata}, {16'd3, 32'h1003});
    wq.delete();
    // rejected and ignored stores
    store(32'h0100_0011, 32'h1, 1'b1);
    store(32'h0100_0000, 32'h2, 1'b0);
    store(32'h0102_5800, 32'h3, 1'b1);
    store(32'h0000_0010, 32'h4, 1'b1);
    cyc();
    chk("drop_count three", drop_count, 3);
    chk("drops no writes", wq.size(), 0);
    repeat (260) store(32'h0100_0002, 32'h5, 1'b1);
    chk("drop_count saturates", drop_count, 8'hFF);
    chk("saturate no writes", {wq.size(), vram_we}, 0);
    // flush then full fill
    vram_grant = 1'b0;
    store(32'h0100_0020, 32'hA, 1'b1);
    store(32'h0100_0024, 32'hB, 1'b1);
    fill_start = 1'b1; fill_value = 32'h0;
    cyc();
    fill_start = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0100_0028; req_data = 32'hC; req_is_word = 1'b1;
    #1 chk("flush blocks push", {req_ready, busy, vram_addr}, {2'b01, 16'd8});
    cyc();
    req_valid = 1'b0;
    vram_grant = 1'b1;
    n = 0;
    while (!fill_done && n < 40000) begin cyc(); n++; end
    chk("fill_done seen", fill_done, 1);
    chk("after fill idle", {vram_we, busy, req_ready}, 3'b001);
    cyc();
    chk("fill_done one cycle", {fill_done, done_cnt}, {1'b0, 32'd1});
    chk("flush+fill write count", wq.size(), 2 + 'h9600);
    bad = 0;
    foreach (wq[i]) begin
      e = i == 0 ? {16'd8, 32'hA} : i == 1 ? {16'd9, 32'hB} : {16'(i - 2), 32'h0};
      if (wq[i] !== e) bad++;
    end
    chk("flush+fill sequence", bad, 0);
    wq.delete();
    // fill with toggled grant, then reset mid-fill
    vram_grant = 1'b0;
    fill_start = 1'b1; fill_value = 32'h1234_5678;
    cyc();
    fill_start = 1'b0;
    for (int k = 0; k < 60; k++) begin vram_grant = k[0]; cyc(); end
    #1 chk("toggled grant index", {vram_we, vram_addr}, {1'b1, 16'd30});
    vram_grant = 1'b1;
    n = 0;
    while (vram_addr != 16'h100 && n < 1000) begin cyc(); n++; end
    chk("reached index 0x100", {vram_we, vram_addr}, {1'b1, 16'h100});
    rst = 1'b0;
    #1 chk("mid-fill reset", {vram_we, busy, drop_count, vram_addr}, 0);
    chk("partial fill count", wq.size(), 'h100);
    bad = 0;
    foreach (wq[i]) if (wq[i] !== {16'(i), 32'h1234_5678}) bad++;
    chk("partial fill sequence", bad, 0);
    cyc(); cyc();
    chk("no writes in reset", wq.size(), 'h100);
    rst = 1'b1;
    #1 chk("ready after second reset", {req_ready, busy}, 2'b10);
    wq.delete();
    store(32'h0100_0040, 32'h55, 1'b1);
    #1 chk("post-reset store", {vram_we, vram_addr, vram_wdata}, {1'b1, 16'h10, 32'h55});
    cyc(); cyc();
    chk("post-reset write", {wq.size(), wq[0]}, {32'd1, 16'h10, 32'h55});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
